imem_arbiter: RTL
=================

Name: imem_arbiter

Overview:
- Shares the single combinational instruction ROM read port between two requesters: the pipeline instruction-fetch (IF) port and a load/debug (LS) port for constant-table and self-check reads.
- Fetch has fixed priority. A starvation counter forces an LS grant after a bounded wait.
- Each accepted request returns one registered response one cycle later.
- Sits between the fetch stage / LSU and the instruction ROM.

Parameters:
- DATA_WIDTH, 32, ROM word width.
- ADDR_WIDTH, 13, ROM byte-address width (ROM holds 2**ADDR_WIDTH bytes).
- BASE_ADDR, 32'h0000_0000, byte address where the ROM is mapped.
- STARVE_LIMIT, 4, number of consecutive stalled LS cycles before LS is forced to win (range 1..15).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_if_valid  in  1  fetch request valid.
- i_if_addr  in  32  fetch byte address.
- i_if_flush  in  1  pipeline flush; blocks fetch grant this cycle.
- o_if_ready  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  fetch response valid (1-cycle pulse).
- o_if_rdata  out  DATA_WIDTH  fetch response data.
- o_if_err  out  1  fetch response access fault.
- i_ls_valid  in  1  LS request valid.
- i_ls_addr  in  32  LS byte address.
- o_ls_ready  out  1  LS request accepted this cycle.
- o_ls_rvalid  out  1  LS response valid (1-cycle pulse).
- o_ls_rdata  out  DATA_WIDTH  LS response data.
- o_ls_err  out  1  LS response access fault.
- o_imem_addr  out  ADDR_WIDTH  byte address driven to the ROM.
- i_imem_data  in  DATA_WIDTH  combinational ROM read data.

Behaviour:
- Reset (async, i_rst_n=0): all rvalid/err outputs 0, all rdata outputs 0, starve counter 0, state IF_PRI. An in-flight response is discarded and is not re-issued after reset.
- Readiness is combinational from the valids, flush and state. A request is accepted when valid & ready are both high at the clock edge.
- At most one port is granted per cycle.
- State IF_PRI:
  - IF is granted if i_if_valid & !i_if_flush.
  - Otherwise LS is granted if i_ls_valid.
- State LS_FORCE:
  - LS is granted if i_ls_valid.
  - Otherwise IF is granted under the IF_PRI rule.
- Starve counter (4 bits, saturating at STARVE_LIMIT):
  - Increments each cycle with i_ls_valid & !o_ls_ready.
  - Clears on LS accept, or when i_ls_valid=0.
- State transitions:
  - IF_PRI -> LS_FORCE when the counter reaches STARVE_LIMIT (the forced grant is effective the following cycle).
  - LS_FORCE -> IF_PRI on LS accept, or when i_ls_valid drops.
- o_imem_addr = granted address minus BASE_ADDR, truncated to ADDR_WIDTH. With no grant it carries the i_if_addr offset (deterministic, ignored).
- Access fault: address is outside [BASE_ADDR, BASE_ADDR + 2**ADDR_WIDTH) or addr[1:0] != 0. The request is still accepted; the response has err=1 and rdata=0.
- Response timing:
  - Response data is i_imem_data sampled at the accept edge.
  - The next cycle the accepted port has rvalid=1 with that data and err.
  - The other port has rvalid=0.
  - rdata/err hold their last values while rvalid=0.
- No response back-pressure: requesters must consume the rvalid pulse. Back-to-back accepts every cycle give full throughput.
- i_if_flush=1:
  - o_if_ready=0 that cycle, and LS may be granted instead.
  - A fetch response already registered still presents its rvalid; the fetch stage discards it.
- Simultaneous valids in IF_PRI with no flush: IF wins and the LS counter increments.

Test Plan:
- Reset, then a single IF read at 0x0000_0008 with ROM[2]=0x00500093 -> o_if_ready=1 in cycle 0; cycle 1 o_if_rvalid=1, o_if_rdata=0x00500093, o_if_err=0.
- IF held valid continuously while LS requests 0x10 with STARVE_LIMIT=4 -> LS stalls 4 cycles, o_ls_ready=1 in the 5th cycle, o_if_ready=0 in that cycle; o_ls_rvalid next cycle with ROM[4]; state returns to IF_PRI.
- LS only, at 0x0000_0006 (misaligned) and 0x0000_2000 (out of range, BASE=0) -> both accepted; responses err=1, rdata=0.
- IF and LS both valid with i_if_flush=1 -> o_ls_ready=1, o_if_ready=0; next cycle only o_ls_rvalid=1.
- Alternating IF addresses 0x0, 0x4, 0x8 for 3 consecutive cycles -> 3 consecutive o_if_rvalid pulses with ROM[0], ROM[1], ROM[2] in order.
- Accept an LS request, then assert i_rst_n=0 mid-cycle before the response -> o_ls_rvalid=0 immediately, counter 0, no response after reset release.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Request/response bundle between the fetch stage, the LS port, the instruction ROM
// and imem_arbiter. The slave modport is the arbiter's view; master is the outside world.
interface imem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic                  i_if_valid;
  logic [31:0]           i_if_addr;
  logic                  i_if_flush;
  logic                  o_if_ready;
  logic                  o_if_rvalid;
  logic [DATA_WIDTH-1:0] o_if_rdata;
  logic                  o_if_err;

  logic                  i_ls_valid;
  logic [31:0]           i_ls_addr;
  logic                  o_ls_ready;
  logic                  o_ls_rvalid;
  logic [DATA_WIDTH-1:0] o_ls_rdata;
  logic                  o_ls_err;

  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [DATA_WIDTH-1:0] i_imem_data;

  modport slave (
    input  i_if_valid, i_if_addr, i_if_flush, i_ls_valid, i_ls_addr, i_imem_data,
    output o_if_ready, o_if_rvalid, o_if_rdata, o_if_err,
    output o_ls_ready, o_ls_rvalid, o_ls_rdata, o_ls_err, o_imem_addr
  );

  modport master (
    output i_if_valid, i_if_addr, i_if_flush, i_ls_valid, i_ls_addr, i_imem_data,
    input  o_if_ready, o_if_rvalid, o_if_rdata, o_if_err,
    input  o_ls_ready, o_ls_rvalid, o_ls_rdata, o_ls_err, o_imem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the combinational instruction ROM: fetch has fixed priority,
// a starvation counter forces an LS grant, responses are registered one cycle later.
module imem_arbiter #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 13,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  imem_arbiter_if.slave  bus
);

  localparam logic [0:0] IF_PRI   = 1'b0;
  localparam logic [0:0] LS_FORCE = 1'b1;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [0:0]            state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  if_err_q, if_err_d;
  logic                  ls_err_q, ls_err_d;

  logic                  if_ok;
  logic                  gnt_if, gnt_ls;
  logic [31:0]           gnt_addr, offset;
  logic                  fault;
  logic [DATA_WIDTH-1:0] resp_data;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    if_ok  = bus.i_if_valid & ~bus.i_if_flush;
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (state_q == LS_FORCE && bus.i_ls_valid) gnt_ls = 1'b1;
    else if (if_ok)                            gnt_if = 1'b1;
    else if (bus.i_ls_valid)                   gnt_ls = 1'b1;
  end

  // With no grant the fetch address still drives the ROM; the result is ignored.
  always_comb begin
    gnt_addr  = gnt_ls ? bus.i_ls_addr : bus.i_if_addr;
    offset    = gnt_addr - BASE_ADDR;
    fault     = (gnt_addr < BASE_ADDR) | (|(offset >> ADDR_WIDTH)) | (|gnt_addr[1:0]);
    resp_data = fault ? '0 : bus.i_imem_data;
  end

  always_comb begin
    starve_d = '0;
    if (bus.i_ls_valid && !gnt_ls)
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;

    state_d = state_q;
    case (state_q)
      IF_PRI:   if (starve_d == LIMIT)              state_d = LS_FORCE;
      LS_FORCE: if (gnt_ls || !bus.i_ls_valid)      state_d = IF_PRI;
      default:                                      state_d = IF_PRI;
    endcase
  end

  always_comb begin
    if_rvalid_d = gnt_if;
    ls_rvalid_d = gnt_ls;
    if_rdata_d  = gnt_if ? resp_data : if_rdata_q;
    if_err_d    = gnt_if ? fault     : if_err_q;
    ls_rdata_d  = gnt_ls ? resp_data : ls_rdata_q;
    ls_err_d    = gnt_ls ? fault     : ls_err_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous
  // so an in-flight response vanishes the moment i_rst_n falls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IF_PRI;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
    end
  end

  assign bus.o_if_ready  = gnt_if;
  assign bus.o_ls_ready  = gnt_ls;
  assign bus.o_imem_addr = offset[ADDR_WIDTH-1:0];
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_if_err    = if_err_q;
  assign bus.o_ls_rvalid = ls_rvalid_q;
  assign bus.o_ls_rdata  = ls_rdata_q;
  assign bus.o_ls_err    = ls_err_q;

endmodule
